// File: rtl/cpu_collector_pkg.sv
// Shared types and helpers for the cpu result collector.
package cpu_collector_pkg;

    localparam int unsigned MAX_CPU = 16;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } state_e;

    function automatic int unsigned src_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Inputs beyond CPU_NB are tied to zero by the caller, so wrapping modulo
    // MAX_CPU visits candidates in the same order as wrapping modulo CPU_NB.
    function automatic logic [3:0] rr_next(input logic [MAX_CPU-1:0] req, input logic [3:0] ptr);
        logic [3:0] idx;
        logic [3:0] grant;
        logic       found;
        grant = ptr;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_CPU; k++) begin
            idx = ptr + 4'(k);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/cpu_collector_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push while full is taken only
// when a pop happens on the same edge.
module cpu_collector_fifo #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic              wr_en;
    logic              rd_en;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (rd_en) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/cpu_collector.sv
// Merges CPU_NB unthrottled cpu result streams into one valid/ready stream via
// per-input FIFOs and a round-robin output register. Optional per-source
// delivery counters and handshake trace are enabled by CPU_COLLECTOR_STATS_EN.
module cpu_collector
    import cpu_collector_pkg::*;
#(
    parameter  int unsigned CPU_NB     = 4,
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned DATA_W     = 64,
    localparam int unsigned SRC_W      = src_w(CPU_NB)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CPU_NB-1:0]        in_vld,
    input  logic [CPU_NB*DATA_W-1:0] in_data,
    input  logic [CPU_NB-1:0]        in_done,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [DATA_W-1:0]        out_data,
    output logic [SRC_W-1:0]         out_src,
    output logic                     all_done,
    output logic [CPU_NB-1:0]        overflow
`ifdef CPU_COLLECTOR_STATS_EN
    ,
    output logic [CPU_NB*32-1:0]     stat_cnt
`endif
);

    logic [DATA_W-1:0] fifo_dout [CPU_NB];
    logic [CPU_NB-1:0] fifo_full;
    logic [CPU_NB-1:0] fifo_empty;
    logic [CPU_NB-1:0] req;
    logic [CPU_NB-1:0] pop;
    logic              load;
    logic [SRC_W-1:0]  grant;

    logic              out_vld_q, out_vld_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SRC_W-1:0]  out_src_q, out_src_d;
    logic [SRC_W-1:0]  rr_q, rr_d;
    logic [CPU_NB-1:0] done_q, done_d;
    logic [CPU_NB-1:0] ovf_q, ovf_d;
    state_e            state_q, state_d;

    for (genvar i = 0; i < CPU_NB; i++) begin : g_fifo
        cpu_collector_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (in_vld[i]),
            .pop   (pop[i]),
            .din   (in_data[i*DATA_W +: DATA_W]),
            .dout  (fifo_dout[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );
    end

    always_comb begin
        req        = ~fifo_empty;
        grant      = SRC_W'(rr_next(MAX_CPU'(req), 4'(rr_q)));
        load       = (!out_vld_q || out_rdy) && (|req);
        pop        = '0;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        rr_d       = rr_q;
        if (load) begin
            pop[grant] = 1'b1;
            out_vld_d  = 1'b1;
            out_data_d = fifo_dout[grant];
            out_src_d  = grant;
            rr_d       = grant;
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end
        done_d = done_q | in_done;
        // A full FIFO still takes a push on the edge it is popped.
        ovf_d  = ovf_q | (in_vld & fifo_full & ~pop);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (&done_q) state_d = DRAIN;
            DRAIN:   if ((&fifo_empty) && !out_vld_q && !(|in_vld)) state_d = DONE;
            DONE:    if (|in_vld) state_d = DRAIN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_src_q  <= '0;
            rr_q       <= SRC_W'(CPU_NB - 1);
            done_q     <= '0;
            ovf_q      <= '0;
            state_q    <= RUN;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            rr_q       <= rr_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_src  = out_src_q;
    assign overflow = ovf_q;
    assign all_done = (state_q == DONE);

`ifdef CPU_COLLECTOR_STATS_EN
    logic [31:0] stat_q [CPU_NB];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CPU_NB; i++) begin
                stat_q[i] <= '0;
            end
        end else if (out_vld_q && out_rdy) begin
            if (stat_q[out_src_q] != '1) begin
                stat_q[out_src_q] <= stat_q[out_src_q] + 32'd1;
            end
            $display("[collector] src %0d 0x%016x", out_src_q, out_data_q);
        end
    end

    for (genvar i = 0; i < CPU_NB; i++) begin : g_stat
        assign stat_cnt[i*32 +: 32] = stat_q[i];
    end
`endif

endmodule

// File: tb/tb_cpu_collector.sv
// Scoreboard bench for cpu_collector: a queue-based reference model predicts
// each output handshake; a negedge monitor compares what the DUT delivers.
module tb_cpu_collector;

    localparam int N     = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_vld;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_done;
    logic            out_vld;
    logic            out_rdy;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            all_done;
    logic [N-1:0]    overflow;

    always #5 clk = ~clk;

    cpu_collector #(
        .CPU_NB     (N),
        .FIFO_DEPTH (DEPTH),
        .DATA_W     (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_done  (in_done),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_src  (out_src),
        .all_done (all_done),
        .overflow (overflow)
    );

    typedef struct {
        int          src;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          hs_log[$];
    logic [63:0] mq [N][$];
    bit          m_ovld;
    logic [63:0] m_odata;
    int          m_osrc;
    int          m_rr;
    logic [N-1:0] m_ovf;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] slot(input int i, input logic [63:0] v);
        logic [N*DW-1:0] d;
        d = '0;
        d[i*DW +: DW] = v;
        return d;
    endfunction

    function automatic bit model_busy();
        bit b;
        b = m_ovld;
        for (int i = 0; i < N; i++) begin
            if (mq[i].size() > 0) b = 1'b1;
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_ovld  = 1'b0;
        m_odata = '0;
        m_osrc  = 0;
        m_rr    = N - 1;
        m_ovf   = '0;
        exp_q.delete();
    endtask

    // Advance the model across one clock edge given the inputs for that edge.
    task automatic model_step(input logic [N-1:0] vld, input logic [N*DW-1:0] data, input bit rdy);
        int g;
        g = -1;
        if (m_ovld && rdy) exp_q.push_back('{m_osrc, m_odata});
        if (!m_ovld || rdy) begin
            for (int k = 1; k <= N && g < 0; k++) begin
                if (mq[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
            end
        end
        if (g >= 0) begin
            m_odata = mq[g].pop_front();
            m_osrc  = g;
            m_rr    = g;
            m_ovld  = 1'b1;
        end else if (rdy) begin
            m_ovld = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (vld[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back(data[i*DW +: DW]);
                else m_ovf[i] = 1'b1;
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] vld, input logic [N*DW-1:0] data, input bit rdy);
        in_vld  = vld;
        in_data = data;
        out_rdy = rdy;
        model_step(vld, data, rdy);
        @(posedge clk);
        #1;
        in_vld = '0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        in_vld  = '0;
        in_data = '0;
        out_rdy = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_all_done(input string tag);
        bit was_idle;
        bit seen;
        was_idle = 1'b0;
        seen     = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            cycle('0, '0, 1'b1);
            if (was_idle) begin
                chk({tag, "_all_done_set"}, 64'(all_done), 64'd1);
                seen = 1'b1;
            end else begin
                chk({tag, "_all_done_pending"}, 64'(all_done), 64'd0);
            end
            was_idle = !model_busy();
        end
        if (!seen) chk({tag, "_all_done_timeout"}, 64'd0, 64'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_vld === 1'b1 && out_rdy === 1'b1) begin
            hs_log.push_back(int'(out_src));
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual src=%0d data=0x%0h required=no output",
                         out_src, out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_src", 64'(out_src), 64'(e.src));
                chk("out_data", out_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0]    v;
        logic [N*DW-1:0] d;

        rst_n   = 1'b0;
        in_vld  = '0;
        in_data = '0;
        in_done = '0;
        out_rdy = 1'b0;
        model_reset();
        do_reset();

        chk("rst_out_vld",  64'(out_vld),  64'd0);
        chk("rst_out_data", out_data,      64'd0);
        chk("rst_out_src",  64'(out_src),  64'd0);
        chk("rst_all_done", 64'(all_done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);

        for (int b = 0; b < 2; b++) begin
            hs_log.delete();
            cycle(4'hF, slot(0, 'hA0) | slot(1, 'hA1) | slot(2, 'hA2) | slot(3, 'hA3), 1'b1);
            repeat (6) cycle('0, '0, 1'b1);
            chk("fair_count", 64'(hs_log.size()), 64'd4);
            for (int i = 0; i < 4 && i < hs_log.size(); i++) begin
                chk($sformatf("fair_src%0d", i), 64'(hs_log[i]), 64'(i));
            end
        end

        cycle(4'b0100, slot(2, 64'h1), 1'b1);
        chk("single_edge0_vld", 64'(out_vld), 64'd0);
        cycle('0, '0, 1'b1);
        chk("single_vld",  64'(out_vld),  64'd1);
        chk("single_data", out_data,      64'h1);
        chk("single_src",  64'(out_src),  64'd2);
        cycle('0, '0, 1'b1);
        chk("single_drop", 64'(out_vld),  64'd0);

        for (int k = 1; k <= 6; k++) cycle(4'b0010, slot(1, 64'(k)), 1'b0);
        chk("ovf_set",   64'(overflow), 64'b0010);
        chk("ovf_model", 64'(overflow), 64'(m_ovf));
        repeat (8) cycle('0, '0, 1'b1);

        for (int k = 0; k < 5; k++) cycle(4'b1000, slot(3, 64'('h70 + k)), 1'b0);
        chk("full_before", 64'(overflow), 64'b0010);
        cycle(4'b1000, slot(3, 64'h77), 1'b1);
        chk("full_pop_no_ovf", 64'(overflow), 64'b0010);
        repeat (8) cycle('0, '0, 1'b1);
        chk("directed_drained", 64'(exp_q.size()), 64'd0);

        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                v[i]          = ($urandom_range(0, 2) == 0);
                d[i*DW +: DW] = {$urandom, $urandom};
            end
            cycle(v, d, $urandom_range(0, 3) != 0);
        end
        repeat (30) cycle('0, '0, 1'b1);
        chk("rand_overflow", 64'(overflow), 64'(m_ovf));
        chk("rand_drained",  64'(exp_q.size()), 64'd0);

        for (int k = 0; k < 3; k++) cycle(4'b0001, slot(0, 64'('hB0 + k)), 1'b0);
        chk("pre_rst_vld", 64'(out_vld), 64'd1);
        do_reset();
        chk("mid_rst_out_vld",  64'(out_vld),  64'd0);
        chk("mid_rst_out_data", out_data,      64'd0);
        chk("mid_rst_out_src",  64'(out_src),  64'd0);
        chk("mid_rst_overflow", 64'(overflow), 64'd0);
        repeat (10) cycle('0, '0, 1'b1);
        chk("post_rst_idle", 64'(out_vld), 64'd0);

        in_done = '1;
        cycle(4'b0111, slot(0, 'hC0) | slot(1, 'hC1) | slot(2, 'hC2), 1'b0);
        chk("done_pending0", 64'(all_done), 64'd0);
        wait_all_done("compl");

        cycle(4'b0001, slot(0, 'hD0), 1'b1);
        chk("done_cleared_by_push", 64'(all_done), 64'd0);
        wait_all_done("redone");

        chk("final_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
